aes_nslow_scheduler: RTL and testbench
======================================

Name: aes_nslow_scheduler

Overview:
- Round-robin scheduler sharing one N-slowed AES core among NUM_REQ requesters.
- Grants at most one block per cycle into the core and tags each issue with its requester ID.
- Collects the in-order results returned by the core and presents them on a single response stream with ID.
- Uses credit-based flow control so core results never overflow the response buffer; the core has no backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- N, 4, slowing factor of the attached core; informational, only used for the busy-drain check.
- CREDITS, 8, maximum blocks in flight plus buffered results; also the depth of the ID FIFO and the result FIFO.
- ID_W, $clog2(NUM_REQ), requester ID width.

Ports:
- clk, input, 1, clock, rising edge.
- rstn, input, 1, reset, asynchronous, active-low.
- enable, input, 1, permits new grants.
- req_valid, input, NUM_REQ, per-requester block request.
- req_ready, output, NUM_REQ, per-requester accept; one-hot or zero.
- req_plain_text, input, NUM_REQ*128, packed; requester i in bits [128*i +: 128].
- req_cipher_key, input, NUM_REQ*128, packed as above.
- core_start, output, 1, issue strobe to core; one valid block per high cycle.
- core_plain_text, output, 128, issued plaintext.
- core_cipher_key, output, 128, issued key.
- core_done, input, 1, core result strobe; returns in issue order.
- core_cipher_text, input, 128, core result.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, response consumer accept.
- rsp_data, output, 128, ciphertext.
- rsp_id, output, ID_W, requester that issued the block.
- busy, output, 1, any block in flight or buffered.
- err_overflow, output, 1, sticky; core_done received with ID FIFO empty.

Behaviour:
- Reset: all outputs 0, rr pointer 0, credit counter 0, both FIFOs empty, err_overflow 0. Reset is asynchronous and may assert mid-operation; in-flight and buffered results are discarded, and any later core_done raises err_overflow. Core reset is owned by the integrator.
- can_issue = enable & (used < CREDITS), where used counts issued blocks not yet consumed on rsp.
- Arbitration: round-robin starting at rr pointer, over req_valid. req_ready[g] = can_issue & grant[g], combinational from req_valid.
  - Handshake occurs on req_valid[g] & req_ready[g].
  - On handshake, rr pointer <= (g+1) mod NUM_REQ. With no handshake, the pointer holds.
- Issue pipeline: registered. The cycle after a handshake, core_start=1 and core_plain_text/core_cipher_key carry the granted data.
  - core_start=0 otherwise.
  - Data outputs hold their last value when core_start=0.
- ID FIFO: pushes g on handshake cycle; pops on core_done.
- Result FIFO, first-word-fall-through:
  - On core_done with ID FIFO non-empty, push {popped id, core_cipher_text}.
  - With the ID FIFO empty, drop the result and set err_overflow.
- Response: rsp_valid = result FIFO non-empty. rsp_data/rsp_id = head entry, stable while rsp_valid & !rsp_ready. Pop on rsp_valid & rsp_ready.
- used: +1 on request handshake, -1 on response handshake. Both in the same cycle leaves it unchanged. Range 0..CREDITS, never wraps. Result FIFO cannot overflow by construction.
- Same-cycle core_done push and rsp pop on the result FIFO are legal, including when the FIFO is full.
- enable low: no new grants; in-flight blocks complete and drain normally.
- busy = (used != 0) | core_start.
- Latency: request handshake to core_start is 1 cycle. core_done to rsp_valid is 1 cycle, or 0 extra when the FIFO already holds data ahead of it.

Optional Feature:
- AES_SCHED_STATS_EN defined:
  - Adds output issue_count, NUM_REQ*16 packed: per-requester 16-bit handshake counters, wrapping at 65535→0, cleared by reset.
  - Adds output max_used, 4 bits: high-water mark of used.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Single block: requester 2 sends key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → core_start 1 cycle after handshake; rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id 2; busy returns to 0.
- Fairness: all 4 req_valid held high, 12 handshakes → grant order 0,1,2,3 repeating; each requester granted exactly 3.
- Credit stall: rsp_ready=0, continuous requests → exactly 8 handshakes, then req_ready=0. Raising rsp_ready for 1 cycle → exactly 1 more grant.
- Backpressure hold: toggle rsp_ready randomly → rsp_data/rsp_id never change while rsp_valid & !rsp_ready. Responses arrive in issue order, 1000 blocks matched against golden ciphertexts.
- Enable/reset: drop enable with 3 in flight → no grants, 3 responses drain. Assert rstn low mid-flight → all outputs 0. A spurious core_done afterwards → err_overflow=1, rsp_valid stays 0.
- Stats (AES_SCHED_STATS_EN): after fairness test, issue_count = 3 per requester and max_used ≤ 8.

Source files
------------

// File: rtl/aes_nslow_scheduler.sv
// aes_nslow_scheduler
//   Round-robin front end that shares one N-slowed AES core among NUM_REQ
//   requesters. At most one block is issued per cycle through a one-cycle
//   issue register. The requester ID travels through an ID FIFO alongside the
//   core latency. In-order core results are paired with their ID and queued in
//   a first-word-fall-through result FIFO. A credit counter ('used') limits
//   blocks in flight plus buffered results to CREDITS. Because of this limit,
//   the core, which has no backpressure, can never overrun the result FIFO.
//
// Ports
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   enable                    permits new grants
//   req_valid / req_ready     per-requester handshake; req_ready is one-hot or zero
//   req_plain_text/_cipher_key  packed, requester i at [128*i +: 128]
//   core_start, core_plain_text, core_cipher_key   issue strobe and data to the core
//   core_done, core_cipher_text                    in-order result strobe from the core
//   rsp_valid/rsp_ready, rsp_data, rsp_id          response stream (FWFT)
//   busy                      any block in flight or buffered
//   err_overflow              sticky: core_done arrived with no outstanding ID
//
// Optional build macro AES_SCHED_STATS_EN adds two outputs:
//   issue_count               NUM_REQ x 16-bit wrapping per-requester handshake counters
//   max_used                  4-bit high-water mark of the credit counter
module aes_nslow_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int N       = 4,
  parameter int CREDITS = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_plain_text,
  input  logic [NUM_REQ*128-1:0] req_cipher_key,
  output logic                   core_start,
  output logic [127:0]           core_plain_text,
  output logic [127:0]           core_cipher_key,
  input  logic                   core_done,
  input  logic [127:0]           core_cipher_text,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy,
  output logic                   err_overflow
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]  issue_count,
  output logic [3:0]             max_used
`endif
);

  localparam int PW = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int EW = ID_W + 128;
  localparam logic [CW-1:0] CREDITS_C = CW'(CREDITS);

  if (NUM_REQ < 2 || NUM_REQ > 8 || N < 1 || CREDITS < 1) begin : g_bad_params
    $error("aes_nslow_scheduler: unsupported parameter set");
  end

  // Requester index 'k' positions after 'base', modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(CREDITS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit update, saturating at both ends so the counter never wraps.
  function automatic logic [CW-1:0] used_next(input logic [CW-1:0] u,
                                              input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = u;
    if (inc && !dec && u != CREDITS_C) r = u + CW'(1);
    if (dec && !inc && u != '0)        r = u - CW'(1);
    return r;
  endfunction

  logic [ID_W-1:0] r_rr;
  logic            r_run;
  logic [CW-1:0]   r_used;
  logic            w_any;
  logic [ID_W-1:0] w_gidx;
  logic            w_can_issue;
  logic            w_hs;
  logic            w_rsp_hs;
  logic [NUM_REQ-1:0] w_grant;
  logic [127:0]    w_sel_pt;
  logic [127:0]    w_sel_key;
  logic [CW-1:0]   w_used_nxt;

  // Stage p0: arbitration and handshake (combinational from req_valid).
  always_comb begin
    w_any     = 1'b0;
    w_gidx    = '0;
    w_sel_pt  = '0;
    w_sel_key = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && req_valid[rr_idx(r_rr, k)]) begin
        w_any  = 1'b1;
        w_gidx = rr_idx(r_rr, k);
      end
    end
    for (int g = 0; g < NUM_REQ; g++) begin
      if (w_gidx == ID_W'(g)) begin
        w_sel_pt  = req_plain_text[128*g +: 128];
        w_sel_key = req_cipher_key[128*g +: 128];
      end
    end
  end

  // r_run keeps req_ready low while reset is asserted, so no requester can see
  // an accept that the held-in-reset state would silently lose.
  assign w_can_issue = r_run & enable & (r_used < CREDITS_C);
  assign w_grant     = (w_any && w_can_issue) ? (NUM_REQ'(1) << w_gidx) : '0;
  assign w_hs        = |w_grant;
  assign req_ready   = w_grant;
  assign w_rsp_hs    = rsp_valid & rsp_ready;
  assign w_used_nxt  = used_next(r_used, w_hs, w_rsp_hs);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run  <= 1'b0;
      r_rr   <= '0;
      r_used <= '0;
    end else begin
      r_run  <= 1'b1;
      r_used <= w_used_nxt;
      if (w_hs) r_rr <= rr_idx(w_gidx, 1);
    end
  end

  // Stage p1: registered issue to the core.
  logic         r_start_p1;
  logic [127:0] r_pt_p1;
  logic [127:0] r_key_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_start_p1 <= 1'b0;
      r_pt_p1    <= '0;
      r_key_p1   <= '0;
    end else begin
      r_start_p1 <= w_hs;
      if (w_hs) begin
        r_pt_p1  <= w_sel_pt;
        r_key_p1 <= w_sel_key;
      end
    end
  end

  assign core_start      = r_start_p1;
  assign core_plain_text = r_pt_p1;
  assign core_cipher_key = r_key_p1;

  // ID FIFO: pushed at handshake, popped by the in-order core_done.
  // Its occupancy never exceeds used, so a push cannot find it full.
  logic [ID_W-1:0] r_id_mem [CREDITS];
  logic [PW-1:0]   r_id_wp, r_id_rp;
  logic [CW-1:0]   r_id_cnt;
  logic            w_id_pop;
  logic            w_res_push;

  assign w_id_pop   = core_done & (r_id_cnt != '0);
  assign w_res_push = w_id_pop;

  always_ff @(posedge clk) begin
    if (w_hs) r_id_mem[r_id_wp] <= w_gidx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_id_wp      <= '0;
      r_id_rp      <= '0;
      r_id_cnt     <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (w_hs)     r_id_wp <= ptr_inc(r_id_wp);
      if (w_id_pop) r_id_rp <= ptr_inc(r_id_rp);
      r_id_cnt <= r_id_cnt + CW'(w_hs) - CW'(w_id_pop);
      if (core_done && r_id_cnt == '0) err_overflow <= 1'b1;
    end
  end

  // Stage p2: result FIFO, first-word-fall-through. Result occupancy plus
  // outstanding IDs equals used, so a push always finds a free slot.
  logic [EW-1:0] r_res_mem [CREDITS];
  logic [PW-1:0] r_res_wp, r_res_rp;
  logic [CW-1:0] r_res_cnt;
  logic [EW-1:0] w_head;

  always_ff @(posedge clk) begin
    if (w_res_push) r_res_mem[r_res_wp] <= {r_id_mem[r_id_rp], core_cipher_text};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_wp  <= '0;
      r_res_rp  <= '0;
      r_res_cnt <= '0;
    end else begin
      if (w_res_push) r_res_wp <= ptr_inc(r_res_wp);
      if (w_rsp_hs)   r_res_rp <= ptr_inc(r_res_rp);
      r_res_cnt <= r_res_cnt + CW'(w_res_push) - CW'(w_rsp_hs);
    end
  end

  assign w_head    = r_res_mem[r_res_rp];
  assign rsp_valid = (r_res_cnt != '0);
  assign rsp_data  = rsp_valid ? w_head[127:0]     : '0;
  assign rsp_id    = rsp_valid ? w_head[EW-1:128]  : '0;
  assign busy      = (r_used != '0) | r_start_p1;

`ifdef AES_SCHED_STATS_EN
  function automatic logic [3:0] sat4(input int u);
    return (u > 15) ? 4'd15 : 4'(u);
  endfunction

  logic [15:0] r_issue_cnt [NUM_REQ];
  logic [3:0]  r_max_used;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int g = 0; g < NUM_REQ; g++) r_issue_cnt[g] <= '0;
      r_max_used <= '0;
    end else begin
      for (int g = 0; g < NUM_REQ; g++) begin
        if (w_grant[g]) r_issue_cnt[g] <= r_issue_cnt[g] + 16'd1;
      end
      if (sat4(int'(w_used_nxt)) > r_max_used) r_max_used <= sat4(int'(w_used_nxt));
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign issue_count[16*g +: 16] = r_issue_cnt[g];
  end
  assign max_used = r_max_used;
`endif

endmodule

// File: tb/tb_aes_nslow_scheduler.sv
// Directed testbench for aes_nslow_scheduler (NUM_REQ=4, CREDITS=8).
// A behavioural stand-in for the AES core returns results in order after a
// fixed latency. It reproduces the FIPS-197 vector exactly and uses a simple
// keyed mix for every other block. A monitor holds an expected-response queue
// filled at each request handshake and checks response order, data and the
// hold rule under backpressure.
module tb_aes_nslow_scheduler;
  localparam int NR   = 4;
  localparam int NLAT = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn = 1'b1;
  logic              enable;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*128-1:0] req_plain_text;
  logic [NR*128-1:0] req_cipher_key;
  logic              core_start;
  logic [127:0]      core_plain_text;
  logic [127:0]      core_cipher_key;
  logic              core_done;
  logic [127:0]      core_cipher_text;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [127:0]      rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;
  logic              err_overflow;
`ifdef AES_SCHED_STATS_EN
  logic [NR*16-1:0]  issue_count;
  logic [3:0]        max_used;
`endif

  aes_nslow_scheduler #(.NUM_REQ(NR), .N(NLAT), .CREDITS(8)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .enable           (enable),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_plain_text   (req_plain_text),
    .req_cipher_key   (req_cipher_key),
    .core_start       (core_start),
    .core_plain_text  (core_plain_text),
    .core_cipher_key  (core_cipher_key),
    .core_done        (core_done),
    .core_cipher_text (core_cipher_text),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_id           (rsp_id),
    .busy             (busy),
    .err_overflow     (err_overflow)
`ifdef AES_SCHED_STATS_EN
    ,
    .issue_count      (issue_count),
    .max_used         (max_used)
`endif
  );

  // ---------------- core model ----------------
  function automatic logic [127:0] core_f(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  logic [NLAT-1:0] cs_pipe;
  logic [127:0]    ct_pipe [NLAT];
  logic            inj_done = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cs_pipe <= '0;
    else       cs_pipe <= {cs_pipe[NLAT-2:0], core_start};
  end
  always @(posedge clk) begin
    ct_pipe[0] <= core_f(core_plain_text, core_cipher_key);
    for (int i = 1; i < NLAT; i++) ct_pipe[i] <= ct_pipe[i-1];
  end
  assign core_done        = cs_pipe[NLAT-1] | inj_done;
  assign core_cipher_text = inj_done ? 128'hdead_beef : ct_pipe[NLAT-1];

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int rsp_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic [1:0] id; logic [127:0] ct; } exp_t;
  exp_t       exp_q[$];
  exp_t       e_m;
  logic       prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic [1:0] prev_id;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, prev_data);
        chk("hold_id", rsp_id, prev_id);
      end
      for (int g = 0; g < NR; g++) begin
        if (req_valid[g] && req_ready[g]) begin
          exp_q.push_back({2'(g), core_f(req_plain_text[128*g +: 128], req_cipher_key[128*g +: 128])});
          hs_cnt++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          chk("rsp_data", rsp_data, e_m.ct);
          chk("rsp_id", rsp_id, e_m.id);
        end else begin
          chk("rsp_unexpected", rsp_valid, 0);
        end
      end
      prev_stall <= rsp_valid && !rsp_ready;
      prev_data  <= rsp_data;
      prev_id    <= rsp_id;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy !== 1'b0; i++) cyc();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_pt"}, core_plain_text, 0);
    chk({tag, "_core_key"}, core_cipher_key, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_overflow, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int gcnt [NR];
  int base, rbase;
  logic [NR-1:0] eg;

  initial begin
    enable = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    req_plain_text = '0; req_cipher_key = '0;
    #1 rstn = 1'b0;
    #1;
    // reset: every output low even with requests and enable asserted
    chk_all_zero("reset");
    req_valid = '0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc(); cyc();

    // fairness: all requesters asserted, grants rotate 0,1,2,3
    rsp_ready = 1'b1;
    for (int g = 0; g < NR; g++) begin
      req_plain_text[128*g +: 128] = {4{32'h1000_0000 + 32'(g)}};
      req_cipher_key[128*g +: 128] = {4{32'hc0de_0000 + 32'(g)}};
      gcnt[g] = 0;
    end
    req_valid = 4'hf;
    for (int i = 0; i < 12; i++) begin
      #1;
      eg = 4'(1 << (i % 4));
      chk("fair_grant", req_ready, eg);
      for (int g = 0; g < NR; g++) if (req_ready[g]) gcnt[g]++;
      cyc();
    end
    req_valid = '0;
    for (int g = 0; g < NR; g++) chk("fair_count", gcnt[g], 3);
`ifdef AES_SCHED_STATS_EN
    for (int g = 0; g < NR; g++) chk("stats_issue_count", issue_count[16*g +: 16], 16'd3);
    chk("stats_max_used_le8", (max_used <= 4'd8), 1);
`endif
    wait_idle(60);
    chk("fair_drain_busy", busy, 0);
    chk("fair_rsp_count", rsp_cnt, 12);

    // single FIPS-197 block from requester 2
    rsp_ready = 1'b0;
    req_plain_text[128*2 +: 128] = FIPS_PT;
    req_cipher_key[128*2 +: 128] = FIPS_KEY;
    req_valid = 4'b0100;
    #1 chk("single_ready", req_ready, 4'b0100);
    cyc();
    chk("single_core_start", core_start, 1);
    chk("single_core_pt", core_plain_text, FIPS_PT);
    chk("single_core_key", core_cipher_key, FIPS_KEY);
    chk("single_busy", busy, 1);
    req_valid = '0;
    cyc();
    chk("single_start_low", core_start, 0);
    chk("single_pt_hold", core_plain_text, FIPS_PT);
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) cyc();
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_data", rsp_data, FIPS_CT);
    chk("single_rsp_id", rsp_id, 2);
    rsp_ready = 1'b1;
    cyc();
    chk("single_rsp_gone", rsp_valid, 0);
    chk("single_busy_low", busy, 0);

    // credit stall: 8 grants then none while responses are blocked
    rsp_ready = 1'b0;
    req_valid = 4'hf;
    base = hs_cnt;
    repeat (20) cyc();
    chk("credit_grants", hs_cnt - base, 8);
    chk("credit_ready_low", req_ready, 0);
    chk("credit_rsp_valid", rsp_valid, 1);
    base = hs_cnt;
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    repeat (10) cyc();
    chk("credit_one_more", hs_cnt - base, 1);
    chk("credit_ready_low2", req_ready, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(60);
    chk("credit_drain_busy", busy, 0);

    // random backpressure, 1000 blocks
    base = hs_cnt; rbase = rsp_cnt;
    for (int c = 0; c < 20000 && (hs_cnt - base) < 1000; c++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      req_valid = 4'($urandom_range(0, 15));
      for (int g = 0; g < NR; g++) begin
        req_plain_text[128*g +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_cipher_key[128*g +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(100);
    chk("rand_grants", hs_cnt - base, 1000);
    chk("rand_rsps", rsp_cnt - rbase, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_busy", busy, 0);

    // enable low with 3 in flight: no new grants, 3 responses drain
    base = hs_cnt; rbase = rsp_cnt;
    req_valid = 4'hf;
    repeat (3) cyc();
    enable = 1'b0;
    #1 chk("en_ready_low", req_ready, 0);
    repeat (10) cyc();
    wait_idle(40);
    chk("en_grants", hs_cnt - base, 3);
    chk("en_rsps", rsp_cnt - rbase, 3);
    chk("en_busy", busy, 0);
    chk("en_ready_still_low", req_ready, 0);
    req_valid = '0;
    enable = 1'b1;

    // reset mid-flight, then a spurious core_done
    rsp_ready = 1'b0;
    req_valid = 4'hf;
    repeat (3) cyc();
    req_valid = '0;
    repeat (4) cyc();
    chk("rst_pre_rsp_valid", rsp_valid, 1);
    chk("rst_pre_busy", busy, 1);
    req_valid = 4'hf;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    cyc(); cyc();
    req_valid = '0;
    rstn = 1'b1;
    repeat (3) cyc();
    chk("rst_post_err", err_overflow, 0);
    chk("rst_post_rsp_valid", rsp_valid, 0);
    chk("rst_post_busy", busy, 0);
    inj_done = 1'b1;
    cyc();
    inj_done = 1'b0;
    chk("spurious_err", err_overflow, 1);
    chk("spurious_rsp_valid", rsp_valid, 0);
    repeat (2) cyc();
    chk("spurious_err_sticky", err_overflow, 1);
    chk("spurious_rsp_valid2", rsp_valid, 0);
    chk("spurious_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
